// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared types and constants for the sequence detector and its serial source
package seqdet_pkg;
    typedef enum logic {IDLE, SHIFT} ser_state_t;
    localparam int SER_W_DEFAULT = 16;
    localparam logic X_IDLE = 1'b0;
endpackage

// File: rtl/seq_serializer.sv
// seq_serializer: MSB-first parallel-to-serial source driving the detector's x input
module seq_serializer
    import seqdet_pkg::*;
#(
    parameter int W  = SER_W_DEFAULT,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  din,
    input  logic [LW-1:0] len,
    input  logic          load,
    output logic          ready,
    output logic          x,
    output logic          busy,
    output logic          done
);
    ser_state_t    state;
    logic [W-1:0]  sreg;
    logic [W-1:0]  word;
    logic [LW-1:0] cnt;
    logic [LW-1:0] len_c;
    logic          take;
    assign ready = (state == IDLE) || (cnt == LW'(1));
    assign busy  = (state == SHIFT);
    // left-align the selected bits so the first one sits at the MSB
    always_comb begin
        len_c = (len > LW'(W)) ? LW'(W) : len;
        word  = din << (W - int'(len_c));
        take  = load && ready && (len_c != '0);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            x     <= X_IDLE;
            done  <= 1'b0;
        end else begin
            done <= (state == SHIFT) && (cnt == LW'(1));
            if (take) begin
                sreg  <= word;
                x     <= word[W-1];
                cnt   <= len_c;
                state <= SHIFT;
            end else if (state == SHIFT && cnt == LW'(1)) begin
                state <= IDLE;
                x     <= X_IDLE;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                sreg <= sreg << 1;
                x    <= sreg[W-2];
                cnt  <= cnt - LW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed checks of seq_serializer framing, handshake and reset
module tb_seq_serializer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [4:0]  len = '0;
    logic        ready, x, busy, done;
    int          n_cmp = 0;
    int          n_bad = 0;

    seq_serializer #(.W(16)) dut (
        .clk(clk), .reset(reset), .din(din), .len(len), .load(load),
        .ready(ready), .x(x), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        reset = 1'b0;
        #60;
        n_cmp++;
        if ({x, busy, done, ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_hold: {x,busy,done,ready} got %b want 0001", {x, busy, done, ready});
        end
        #65;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({x, busy, done, ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_release: {x,busy,done,ready} got %b want 0001", {x, busy, done, ready});
        end
    endtask

    // ign >= 0 pulses a competing load of 16'hFFFF during bit ign, which must be dropped
    task automatic test_word(input string name, input logic [15:0] d, input logic [4:0] l,
                             input int n, input logic [15:0] e, input int ign);
        @(negedge clk);
        din = d; len = l; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if ({x, busy, done, ready} !== {e[n-1-i], 1'b1, 1'b0, (i == n - 1)}) begin
                n_bad++;
                $display("FAIL %s bit %0d: {x,busy,done,ready} got %b want %b", name, i,
                         {x, busy, done, ready}, {e[n-1-i], 1'b1, 1'b0, (i == n - 1)});
            end
            if (i == ign) begin
                din = 16'hFFFF; len = 5'd4; load = 1'b1;
            end
            if (i == ign + 1) load = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if ({x, busy, done, ready} !== 4'b0011) begin
            n_bad++;
            $display("FAIL %s done: {x,busy,done,ready} got %b want 0011", name, {x, busy, done, ready});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({x, busy, done, ready} !== 4'b0001) begin
                n_bad++;
                $display("FAIL %s idle %0d: {x,busy,done,ready} got %b want 0001", name, i, {x, busy, done, ready});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] ex, eb, ed;
        ex = 6'b101100;
        eb = 6'b111110;
        ed = 6'b000101;
        @(negedge clk);
        din = 16'h0005; len = 5'd3; load = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if ({x, busy, done} !== {ex[5-j], eb[5-j], ed[5-j]}) begin
                n_bad++;
                $display("FAIL b2b cycle %0d: {x,busy,done} got %b want %b", j,
                         {x, busy, done}, {ex[5-j], eb[5-j], ed[5-j]});
            end
            if (j == 0) begin
                din = 16'h0002; len = 5'd2;
            end
            if (j == 3) load = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if ({x, busy, done, ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL b2b idle: {x,busy,done,ready} got %b want 0001", {x, busy, done, ready});
        end
    endtask

    task automatic test_len0;
        @(negedge clk);
        din = 16'hFFFF; len = 5'd0; load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({x, busy, done, ready} !== 4'b0001) begin
                n_bad++;
                $display("FAIL len0 cycle %0d: {x,busy,done,ready} got %b want 0001", i, {x, busy, done, ready});
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        din = 16'h04B7; len = 5'd11; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({x, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL midrst pre: {x,busy} got %b want 01", {x, busy});
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({x, busy, done, ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL midrst async: {x,busy,done,ready} got %b want 0001", {x, busy, done, ready});
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({x, busy, done, ready} !== 4'b0001) begin
                n_bad++;
                $display("FAIL midrst after %0d: {x,busy,done,ready} got %b want 0001", i, {x, busy, done, ready});
            end
        end
    endtask

    initial begin
        test_reset;
        test_word("detector", 16'h04B7, 5'd11, 11, 16'h04B7, -1);
        test_back_to_back;
        test_len0;
        test_word("len1", 16'h8003, 5'd1, 1, 16'h0001, -1);
        test_word("len20", 16'hA5C3, 5'd20, 16, 16'hA5C3, -1);
        test_word("ignored", 16'h04B7, 5'd11, 11, 16'h04B7, 2);
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial bit source that sits directly upstream of the sequence detector and drives its serial `x` input. A producer loads a word and a bit count over a ready/load handshake. The block shifts the selected bits out MSB-first, one bit per clock, and holds `x` low when idle. Back-to-back loads are accepted on the final bit so the detector sees a gapless stream.

## Interface
Parameters:
- `W`, default 16: shift register width and maximum bits per load.
- `LW`, default `$clog2(W+1)`: width of `len`.

Ports:
- `clk`, input, 1: rising-edge clock shared with the detector.
- `reset`, input, 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `din`, input, W: bits to send; `din[len-1]` is sent first and `din[0]` last.
- `len`, input, LW: number of bits to send; valid range 1..W.
- `load`, input, 1: request; accepted on a rising edge where `load && ready`.
- `ready`, output, 1: block can accept a load this cycle (combinational from state).
- `x`, output, 1: registered serial bit to the detector.
- `busy`, output, 1: registered; high while a word is being shifted.
- `done`, output, 1: registered one-cycle pulse after the last bit of a word.

## Operation
- States: IDLE and SHIFT. The state register is `busy`.
- Registers: `sreg[W-1:0]`, `cnt[LW-1:0]`, `x`, `done`.
- Reset (asserted low) forces, asynchronously: state=IDLE, `sreg`=0, `cnt`=0, `x`=0, `busy`=0, `done`=0. `ready` is therefore 1 during and after reset.
- `ready` = (state==IDLE) || (state==SHIFT && cnt==1).
- Accepted load, with `len` clamped to W if greater than W:
  - `sreg <= din << (W-len)`
  - `x <= din[len-1]`
  - `cnt <= len`
  - state <= SHIFT
- `len==0` with `load`: ignored. No state change, no `done`, and `ready` stays high.
- SHIFT with cnt>1:
  - `sreg <= sreg << 1`
  - `x <= sreg[W-2]` (the next bit)
  - `cnt <= cnt-1`
- SHIFT with cnt==1 and no load: state <= IDLE, `x` <= 0, `done` <= 1.
- SHIFT with cnt==1 and an accepted load: `done` <= 1 and the new word starts as for a normal load. `x` carries the new first bit on the next cycle with no idle gap, and state stays SHIFT.
- `done` is high for exactly one cycle per completed word, otherwise 0.
- `load` while `ready`=0 is ignored. The producer must hold `load` until it sees `ready`.
- Reset mid-word aborts the word: no `done`, and `x`=0 immediately.

## Timing
- Load accepted at edge k means bit i (i=0 is first) is on `x` from edge k+i to k+i+1. The detector samples bit i at edge k+i+1.
- Latency from load to the first bit on `x` is one clock.
- `busy` rises at edge k and falls at edge k+len when no back-to-back load occurs.
- `done` is high during cycle k+len, in the interval from edge k+len to k+len+1.
- Throughput is one bit per clock, sustained indefinitely with back-to-back loads.
- `x` is glitch-free because it is driven directly from a flop.

## Structure
- Shared package `seqdet_pkg` holds:
  - state enum `ser_state_t` {IDLE, SHIFT}
  - `SER_W_DEFAULT` = 16
  - idle line value `X_IDLE` = 1'b0
- No sub-module is needed. The counter and shift register are in a single always block, with the `ready` logic as a single continuous assign.

## Test plan
- Reset: hold `reset`=0 for 125 ns, then release. Expect `x`=0, `busy`=0, `done`=0, `ready`=1.
- Detector stimulus: load `din`=16'h04B7, `len`=11. Expect `x` = 1,0,0,1,0,1,1,0,1,1,1 on 11 consecutive cycles, then `done` high for one cycle and `x`=0.
- Back-to-back: load 16'h0005 (`len`=3), then load 16'h0002 (`len`=2) during the cycle where cnt==1. Expect `x`=1,0,1,1,0 with no gap, `busy` continuously high, and two `done` pulses two cycles apart.
- Length edges:
  - `len`=0: no activity.
  - `len`=1 with `din[0]`=1: exactly one `x`=1 cycle, then `done`.
  - `len`=20: clamped to 16, so 16 bits are sent, MSB `din[15]` first.
- Ignored load: assert `load` with a new word while the block is mid-word (cnt>1). The current word completes unchanged and the new word is never sent.
- Reset mid-word: assert `reset` low two bits into an 11-bit word. Expect `x`, `busy` and `done` at 0 immediately, no `done` pulse, and `ready`=1 after release.
